// File: rtl/msg_issue_scheduler_if.sv
// rtl/msg_issue_scheduler_if.sv - host ingress, parser issue and monitor signals of the issue scheduler
interface msg_issue_scheduler_if #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 9,
    parameter int FIFO_DEPTH = 8
);
    localparam int MSG_W = NUM_REGS * REG_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              i_msg_valid;
    logic [MSG_W-1:0]  i_msg;
    logic              o_msg_ready;
    logic              i_book_is_busy;
    logic              i_enable;
    logic              o_data_valid;
    logic [MSG_W-1:0]  o_msg;
    logic [CNT_W-1:0]  o_fifo_count;
    logic              o_overflow;
    logic [31:0]       o_issued_count;

    modport slave (
        input  i_msg_valid, i_msg, i_book_is_busy, i_enable,
        output o_msg_ready, o_data_valid, o_msg, o_fifo_count, o_overflow, o_issued_count
    );

    modport master (
        output i_msg_valid, i_msg, i_book_is_busy, i_enable,
        input  o_msg_ready, o_data_valid, o_msg, o_fifo_count, o_overflow, o_issued_count
    );
endinterface

// File: rtl/msg_issue_scheduler.sv
// rtl/msg_issue_scheduler.sv - message FIFO with paced, busy-gated single-cycle issue to the parser
module msg_issue_scheduler #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_GAP    = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    msg_issue_scheduler_if.slave bus
);
    localparam int MSG_W = NUM_REGS * REG_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int GAP_W = $clog2(MIN_GAP);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [MSG_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [GAP_W-1:0]  r_gap;
    logic [MSG_W-1:0]  r_msg;
    logic              r_overflow;
    logic [31:0]       r_issued_count;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_eligible;

    // Ready comes from the registered count only, so a same-cycle pop never reopens a full FIFO.
    assign w_ready    = (r_count != FULL_CNT);
    assign w_push     = bus.i_msg_valid && w_ready;
    assign w_eligible = (r_count != '0) && bus.i_enable && !bus.i_book_is_busy;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_pop        = 1'b1;
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == '0) w_next_state = w_eligible ? ST_ISSUE : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.i_msg;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_gap          <= '0;
            r_msg          <= '0;
            r_overflow     <= 1'b0;
            r_issued_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (bus.i_msg_valid && !w_ready) r_overflow <= 1'b1;
            // Capture the head on the edge entering ISSUE so o_msg is valid alongside the pulse.
            if (w_next_state == ST_ISSUE) r_msg <= r_mem[r_rd_ptr];
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + 1'b1;
                r_issued_count <= r_issued_count + 32'd1;
                r_gap          <= GAP_LOAD;
            end else if (r_state == ST_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign bus.o_msg_ready    = w_ready;
    assign bus.o_data_valid   = (r_state == ST_ISSUE);
    assign bus.o_msg          = r_msg;
    assign bus.o_fifo_count   = r_count;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_issued_count = r_issued_count;
endmodule

// File: tb/tb_msg_issue_scheduler.sv
// tb/tb_msg_issue_scheduler.sv - directed self-checking bench for msg_issue_scheduler
module tb_msg_issue_scheduler;
    localparam int REG_WIDTH  = 32;
    localparam int NUM_REGS   = 9;
    localparam int FIFO_DEPTH = 8;
    localparam int MIN_GAP    = 4;
    localparam int MSG_W      = NUM_REGS * REG_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    msg_issue_scheduler_if #(.REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

    msg_issue_scheduler #(
        .REG_WIDTH(REG_WIDTH), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP(MIN_GAP)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [MSG_W-1:0] mk(input logic [31:0] w0);
        logic [MSG_W-1:0] m;
        for (int n = 0; n < NUM_REGS; n++) m[n*REG_WIDTH +: REG_WIDTH] = w0 + 32'(n) * 32'h0100_0000;
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_if.i_msg_valid = 1'b0; bus_if.i_msg = '0;
        bus_if.i_book_is_busy = 1'b0; bus_if.i_enable = 1'b1;
        tick; tick;
        rst_n = 1'b1;
        checks++; if (bus_if.o_msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus_if.o_msg_ready); end
        checks++; if (bus_if.o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_if.o_data_valid); end
        checks++; if (bus_if.o_msg !== '0) begin errors++; $display("FAIL reset_msg got %h exp 0", bus_if.o_msg[31:0]); end
        checks++; if (bus_if.o_fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus_if.o_fifo_count); end
        checks++; if (bus_if.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus_if.o_overflow); end
        checks++; if (bus_if.o_issued_count !== 32'd0) begin errors++; $display("FAIL reset_issued got %0d exp 0", bus_if.o_issued_count); end
    endtask

    task automatic test_single;
        bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'hA5A5_0001);
        tick;
        bus_if.i_msg_valid = 1'b0;
        checks++; if (bus_if.o_fifo_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bus_if.o_fifo_count); end
        checks++; if (bus_if.o_data_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bus_if.o_data_valid); end
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1) begin errors++; $display("FAIL single_pulse got %b exp 1", bus_if.o_data_valid); end
        checks++; if (bus_if.o_msg !== mk(32'hA5A5_0001)) begin errors++; $display("FAIL single_msg got %h exp a5a50001", bus_if.o_msg[31:0]); end
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b0) begin errors++; $display("FAIL single_width got %b exp 0", bus_if.o_data_valid); end
        checks++; if (bus_if.o_issued_count !== 32'd1) begin errors++; $display("FAIL single_issued got %0d exp 1", bus_if.o_issued_count); end
        checks++; if (bus_if.o_fifo_count !== 4'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", bus_if.o_fifo_count); end
        checks++; if (bus_if.o_msg !== mk(32'hA5A5_0001)) begin errors++; $display("FAIL single_hold got %h exp a5a50001", bus_if.o_msg[31:0]); end
        repeat (5) tick;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int last = -1;
        int first = -1;
        logic ready_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus_if.i_msg_valid = (c < 8);
            bus_if.i_msg = mk(32'(c + 1));
            tick;
            if (!bus_if.o_msg_ready) ready_ok = 1'b0;
            if (bus_if.o_data_valid) begin
                checks++;
                if (bus_if.o_msg !== mk(32'(n + 1))) begin errors++; $display("FAIL burst_data[%0d] got %h exp %0d", n, bus_if.o_msg[31:0], n + 1); end
                if (n > 0) begin
                    checks++;
                    if (c - last != MIN_GAP) begin errors++; $display("FAIL burst_spacing[%0d] got %0d exp %0d", n, c - last, MIN_GAP); end
                end else first = c;
                last = c;
                n++;
            end
        end
        bus_if.i_msg_valid = 1'b0;
        checks++; if (first != 1) begin errors++; $display("FAIL burst_latency got %0d exp 1", first); end
        checks++; if (n != 8) begin errors++; $display("FAIL burst_pulses got %0d exp 8", n); end
        checks++; if (ready_ok !== 1'b1) begin errors++; $display("FAIL burst_ready got 0 exp 1"); end
        checks++; if (bus_if.o_issued_count !== 32'd9) begin errors++; $display("FAIL burst_issued got %0d exp 9", bus_if.o_issued_count); end
    endtask

    task automatic test_overflow;
        int n = 0;
        bus_if.i_enable = 1'b0;
        for (int c = 0; c < 9; c++) begin
            bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'(c + 1));
            tick;
            if (c == 7) begin
                checks++; if (bus_if.o_fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count8 got %0d exp 8", bus_if.o_fifo_count); end
                checks++; if (bus_if.o_msg_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", bus_if.o_msg_ready); end
                checks++; if (bus_if.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", bus_if.o_overflow); end
            end
        end
        bus_if.i_msg_valid = 1'b0;
        checks++; if (bus_if.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus_if.o_overflow); end
        checks++; if (bus_if.o_fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_dropped got %0d exp 8", bus_if.o_fifo_count); end
        bus_if.i_enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick;
            if (bus_if.o_data_valid) begin
                checks++;
                if (bus_if.o_msg !== mk(32'(n + 1))) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %0d", n, bus_if.o_msg[31:0], n + 1); end
                n++;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL ovf_pulses got %0d exp 8", n); end
        checks++; if (bus_if.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus_if.o_overflow); end
        checks++; if (bus_if.o_fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", bus_if.o_fifo_count); end
    endtask

    task automatic test_busy;
        logic quiet = 1'b1;
        bus_if.i_book_is_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'h31 + 32'(c));
            tick;
        end
        bus_if.i_msg_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (bus_if.o_data_valid) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL busy_hold got pulse exp none"); end
        checks++; if (bus_if.o_fifo_count !== 4'd3) begin errors++; $display("FAIL busy_count got %0d exp 3", bus_if.o_fifo_count); end
        bus_if.i_book_is_busy = 1'b0;
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h31)) begin errors++; $display("FAIL busy_release got v=%b %h exp v=1 31", bus_if.o_data_valid, bus_if.o_msg[31:0]); end
        bus_if.i_book_is_busy = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (bus_if.o_data_valid) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL busy_gap got pulse exp none"); end
        bus_if.i_book_is_busy = 1'b0;
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h32)) begin errors++; $display("FAIL busy_second got v=%b %h exp v=1 32", bus_if.o_data_valid, bus_if.o_msg[31:0]); end
        quiet = 1'b1;
        for (int c = 0; c < MIN_GAP - 1; c++) begin
            tick;
            if (bus_if.o_data_valid) quiet = 1'b0;
        end
        tick;
        checks++; if (quiet !== 1'b1 || bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h33)) begin
            errors++; $display("FAIL busy_third got quiet=%b v=%b %h exp quiet=1 v=1 33", quiet, bus_if.o_data_valid, bus_if.o_msg[31:0]);
        end
        repeat (5) tick;
    endtask

    task automatic test_reset_mid;
        bus_if.i_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'h51 + 32'(c));
            tick;
        end
        bus_if.i_msg_valid = 1'b0;
        bus_if.i_enable = 1'b1;
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h51)) begin errors++; $display("FAIL rmid_issue got v=%b %h exp v=1 51", bus_if.o_data_valid, bus_if.o_msg[31:0]); end
        tick;
        rst_n = 1'b0;
        tick;
        checks++; if (bus_if.o_msg_ready !== 1'b1 || bus_if.o_data_valid !== 1'b0 || bus_if.o_msg !== '0) begin
            errors++; $display("FAIL rmid_outputs got rdy=%b v=%b msg=%h exp 1 0 0", bus_if.o_msg_ready, bus_if.o_data_valid, bus_if.o_msg[31:0]);
        end
        checks++; if (bus_if.o_fifo_count !== 4'd0 || bus_if.o_overflow !== 1'b0 || bus_if.o_issued_count !== 32'd0) begin
            errors++; $display("FAIL rmid_counters got cnt=%0d ovf=%b iss=%0d exp 0 0 0", bus_if.o_fifo_count, bus_if.o_overflow, bus_if.o_issued_count);
        end
        rst_n = 1'b1;
        bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'h61);
        tick;
        bus_if.i_msg_valid = 1'b0;
        checks++; if (bus_if.o_fifo_count !== 4'd1 || bus_if.o_data_valid !== 1'b0) begin errors++; $display("FAIL rmid_push got cnt=%0d v=%b exp 1 0", bus_if.o_fifo_count, bus_if.o_data_valid); end
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h61)) begin errors++; $display("FAIL rmid_reissue got v=%b %h exp v=1 61", bus_if.o_data_valid, bus_if.o_msg[31:0]); end
        tick;
        checks++; if (bus_if.o_issued_count !== 32'd1 || bus_if.o_fifo_count !== 4'd0) begin errors++; $display("FAIL rmid_after got iss=%0d cnt=%0d exp 1 0", bus_if.o_issued_count, bus_if.o_fifo_count); end
        repeat (5) tick;
    endtask

    task automatic test_wrap;
        force dut.r_issued_count = 32'hFFFF_FFFF;
        tick;
        release dut.r_issued_count;
        tick;
        checks++; if (bus_if.o_issued_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", bus_if.o_issued_count); end
        bus_if.i_msg_valid = 1'b1; bus_if.i_msg = mk(32'h71);
        tick;
        bus_if.i_msg_valid = 1'b0;
        tick;
        checks++; if (bus_if.o_data_valid !== 1'b1 || bus_if.o_msg !== mk(32'h71)) begin errors++; $display("FAIL wrap_issue got v=%b %h exp v=1 71", bus_if.o_data_valid, bus_if.o_msg[31:0]); end
        tick;
        checks++; if (bus_if.o_issued_count !== 32'd0) begin errors++; $display("FAIL wrap_count got %h exp 0", bus_if.o_issued_count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_busy;
        test_reset_mid;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/msg_issue_scheduler.md
# msg_issue_scheduler

Ingress scheduler in front of the trading pipeline's parser. It accepts 9-word inbound market messages from the host on a valid/ready interface and buffers them in a small FIFO. It issues them to the parser one at a time, holding back while the order book reports busy and enforcing a minimum spacing between issues so the order book, trading logic and reverse parser stages are never overrun. It also reports occupancy, a sticky drop flag and an issue counter for host monitoring.

## Interface
- REG_WIDTH, 32, width of one message word
- NUM_REGS, 9, words per message (reg_0 is the lowest slice of the flat bus)
- FIFO_DEPTH, 8, message buffer depth; power of two, ≥2
- MIN_GAP, 4, minimum cycles between consecutive issue pulses; ≥2
- CNT_W, $clog2(FIFO_DEPTH)+1, derived localparam

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset; synchronous, active-low
- i_msg_valid  in  1  host message valid
- i_msg  in  NUM_REGS*REG_WIDTH  host message, word n at [n*REG_WIDTH +: REG_WIDTH]
- o_msg_ready  out  1  buffer can accept
- i_book_is_busy  in  1  order book busy; blocks new issues
- i_enable  in  1  issue enable (host pause when low)
- o_data_valid  out  1  single-cycle issue pulse to the parser
- o_msg  out  NUM_REGS*REG_WIDTH  issued message
- o_fifo_count  out  CNT_W  messages buffered
- o_overflow  out  1  sticky: a message was offered while not ready
- o_issued_count  out  32  total messages issued, wraps modulo 2^32

## Operation
- Reset (sampled i_reset_n=0 at an edge): FIFO emptied (contents discarded), pointers and counts cleared, state IDLE, gap counter 0. o_msg_ready=1, o_data_valid=0, o_msg=0, o_fifo_count=0, o_overflow=0, o_issued_count=0. Reset mid-issue or mid-gap aborts immediately and drops the message.
- Push: on an edge with i_msg_valid && o_msg_ready, write i_msg at the write pointer. o_msg_ready = (o_fifo_count != FIFO_DEPTH), derived from the registered count.
- A push offered while full is dropped and sets o_overflow. o_overflow clears only on reset.
- Ready stays low when full even if a pop occurs that same cycle.
- Pointers wrap at FIFO_DEPTH. On a simultaneous push and pop, the count is unchanged.
- Eligible = (o_fifo_count != 0) && i_enable && !i_book_is_busy.
- State machine:
  - IDLE: if eligible → ISSUE.
  - ISSUE: o_data_valid=1; o_msg = FIFO head; pop; o_issued_count+1; gap counter ← MIN_GAP-2; → GAP.
  - GAP: if counter != 0, decrement and stay. If counter == 0: → ISSUE if eligible, else → IDLE.
- o_msg is registered. It holds the last issued message between pulses.
- Once ISSUE is entered, it completes regardless of i_book_is_busy or i_enable.
- i_enable low stops issuing only; acceptance continues.

## Timing
- Accept edge k: o_fifo_count updates at k+1, and o_data_valid is high in cycle k+2 if eligible at k+1. Minimum ingress-to-issue latency is 2 cycles.
- Issue pulses are exactly 1 cycle wide. Spacing between pulses is ≥ MIN_GAP cycles, and exactly MIN_GAP under continuous eligibility (ISSUE at t, GAP t+1..t+MIN_GAP-1, ISSUE at t+MIN_GAP).
- i_book_is_busy and i_enable are sampled only in IDLE and in the final GAP cycle. When busy deasserts in cycle c, the issue occurs at c+1.
- Sustained throughput is 1 message per MIN_GAP cycles. The FIFO absorbs bursts up to FIFO_DEPTH.
- Issue order is strictly FIFO. No message is duplicated or reordered.

## Test plan
- Reset, then push one message with word0=0xA5A5_0001 at edge k → o_data_valid high in cycle k+2 only, o_msg word0=0xA5A5_0001, o_issued_count=1, o_fifo_count returns to 0.
- Burst of 8 pushes (word0=1..8) back-to-back, MIN_GAP=4, busy low → 8 pulses exactly 4 cycles apart carrying 1..8 in order; o_msg_ready never drops.
- With i_enable=0, push 9 messages → first 8 accepted, o_msg_ready=0 at count 8, 9th dropped, o_overflow=1 and stays 1. Then i_enable=1 → 8 issues, word0=1..8.
- Hold i_book_is_busy=1 with 3 messages buffered for 20 cycles → no pulse. Deassert busy in cycle c → pulse at c+1 and subsequent pulses every 4 cycles. Busy asserted during GAP defers the next issue until it clears.
- Assert reset in the GAP cycle after an issue, with 5 messages buffered → all outputs at reset values next cycle. New push issues 2 cycles later with correct data.
- Preload o_issued_count near wrap (0xFFFF_FFFF via 2^32-1 issues or a forced value in simulation) → the next issue wraps it to 0.
